// File: rtl/pipe_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy states
// and the default bubble word.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  localparam logic [31:0] NOP_VAL = 32'h0000_0000;

  // Upstream may only be accepted while the skid slot is free.
  function automatic logic ready_for(input stage_state_e state);
    return (state != ST_TWO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts one per cycle with inc high and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_r;

  // Count register with saturation at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid pipeline stage: registered ready/valid on both sides, flush,
// and saturating stall/flush performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       PC_W    = 32,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(pipe_pkg::NOP_VAL),
  parameter int unsigned       CNT_W   = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [PC_W-1:0]   i_pc,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PC_W-1:0]   o_pc,
  output logic [DATA_W-1:0] o_data,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  stage_state_e      state_r;
  logic              valid_r;
  logic              ready_r;
  logic [PC_W-1:0]   main_pc_r;
  logic [DATA_W-1:0] main_data_r;
  logic [PC_W-1:0]   skid_pc_r;
  logic [DATA_W-1:0] skid_data_r;

  logic in_fire_s;
  logic out_fire_s;
  logic stall_inc_s;
  logic flush_inc_s;

  assign in_fire_s   = i_valid & ready_r;
  assign out_fire_s  = valid_r & i_ready;
  assign stall_inc_s = valid_r & ~i_ready & ~i_flush;
  assign flush_inc_s = i_flush & (state_r != ST_EMPTY);

  // Occupancy FSM; main/skid storage and handshake outputs all registered here.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_EMPTY;
      valid_r     <= 1'b0;
      ready_r     <= 1'b0;
      main_pc_r   <= {PC_W{1'b0}};
      main_data_r <= NOP_VAL;
      skid_pc_r   <= {PC_W{1'b0}};
      skid_data_r <= NOP_VAL;
    end else if (i_flush) begin
      // A simultaneous in_fire is dropped along with everything held.
      state_r     <= ST_EMPTY;
      valid_r     <= 1'b0;
      ready_r     <= ready_for(ST_EMPTY);
      main_pc_r   <= {PC_W{1'b0}};
      main_data_r <= NOP_VAL;
      skid_pc_r   <= {PC_W{1'b0}};
      skid_data_r <= NOP_VAL;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          ready_r <= ready_for(ST_EMPTY);
          if (in_fire_s) begin
            state_r     <= ST_ONE;
            valid_r     <= 1'b1;
            main_pc_r   <= i_pc;
            main_data_r <= i_data;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            state_r     <= ST_ONE;
            ready_r     <= ready_for(ST_ONE);
            main_pc_r   <= i_pc;
            main_data_r <= i_data;
          end else if (in_fire_s) begin
            state_r     <= ST_TWO;
            ready_r     <= ready_for(ST_TWO);
            skid_pc_r   <= i_pc;
            skid_data_r <= i_data;
          end else if (out_fire_s) begin
            // Draining to empty puts the bubble back on the outputs.
            state_r     <= ST_EMPTY;
            valid_r     <= 1'b0;
            ready_r     <= ready_for(ST_EMPTY);
            main_pc_r   <= {PC_W{1'b0}};
            main_data_r <= NOP_VAL;
          end else begin
            state_r <= ST_ONE;
            ready_r <= ready_for(ST_ONE);
          end
        end
        ST_TWO: begin
          if (out_fire_s) begin
            state_r     <= ST_ONE;
            ready_r     <= ready_for(ST_ONE);
            main_pc_r   <= skid_pc_r;
            main_data_r <= skid_data_r;
            skid_pc_r   <= {PC_W{1'b0}};
            skid_data_r <= NOP_VAL;
          end else begin
            state_r <= ST_TWO;
            ready_r <= ready_for(ST_TWO);
          end
        end
        default: begin
          state_r     <= ST_EMPTY;
          valid_r     <= 1'b0;
          ready_r     <= ready_for(ST_EMPTY);
          main_pc_r   <= {PC_W{1'b0}};
          main_data_r <= NOP_VAL;
          skid_pc_r   <= {PC_W{1'b0}};
          skid_data_r <= NOP_VAL;
        end
      endcase
    end
  end

  assign o_valid = valid_r;
  assign o_ready = ready_r;
  assign o_pc    = main_pc_r;
  assign o_data  = main_data_r;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (stall_inc_s),
    .count (o_stall_cnt)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (flush_inc_s),
    .count (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: a queue model tracks held entries,
// ready and both counters cycle by cycle; scenario tasks add targeted checks.
module tb_pipe_stage_skid;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam logic [DATA_W-1:0] NOP = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic              o_ready;
  logic [PC_W-1:0]   i_pc;
  logic [DATA_W-1:0] i_data;
  logic              i_flush;
  logic              o_valid;
  logic              i_ready;
  logic [PC_W-1:0]   o_pc;
  logic [DATA_W-1:0] o_data;
  logic [CNT_W-1:0]  o_stall_cnt;
  logic [CNT_W-1:0]  o_flush_cnt;

  entry_t           sb_q[$];
  logic             m_ready;
  logic [CNT_W-1:0] m_stall;
  logic [CNT_W-1:0] m_flush;
  int               checks;
  int               errors;

  pipe_stage_skid #(
    .PC_W    (PC_W),
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP),
    .CNT_W   (CNT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_pc        (i_pc),
    .i_data      (i_data),
    .i_flush     (i_flush),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_pc        (o_pc),
    .o_data      (o_data),
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] data_of(input logic [PC_W-1:0] pc);
    return pc ^ 32'hDEAD_BEEF;
  endfunction

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic v, input logic [PC_W-1:0] pc,
                      input logic rdy, input logic fl);
    logic   in_f;
    logic   out_f;
    entry_t e;
    i_valid = v; i_pc = pc; i_data = data_of(pc); i_ready = rdy; i_flush = fl;
    #1;
    checks++;
    if (o_valid !== (sb_q.size() != 0)) begin
      errors++; $display("FAIL sb_valid: got %b want %b", o_valid, (sb_q.size() != 0));
    end
    checks++;
    if (o_ready !== m_ready) begin
      errors++; $display("FAIL sb_ready: got %b want %b", o_ready, m_ready);
    end
    if (sb_q.size() != 0) begin
      checks++;
      if (o_pc !== sb_q[0].pc || o_data !== sb_q[0].data) begin
        errors++; $display("FAIL sb_entry: got pc %h data %h want pc %h data %h",
                           o_pc, o_data, sb_q[0].pc, sb_q[0].data);
      end
    end else begin
      checks++;
      if (o_pc !== 32'h0 || o_data !== NOP) begin
        errors++; $display("FAIL sb_bubble: got pc %h data %h want pc 0 data %h", o_pc, o_data, NOP);
      end
    end
    checks++;
    if (o_stall_cnt !== m_stall || o_flush_cnt !== m_flush) begin
      errors++; $display("FAIL sb_counters: got stall %0d flush %0d want stall %0d flush %0d",
                         o_stall_cnt, o_flush_cnt, m_stall, m_flush);
    end
    in_f  = v & m_ready;
    out_f = (sb_q.size() != 0) & rdy;
    if (fl) begin
      if (sb_q.size() != 0 && m_flush != 4'hF) m_flush = m_flush + 4'd1;
      sb_q.delete();
    end else begin
      if (sb_q.size() != 0 && !rdy && m_stall != 4'hF) m_stall = m_stall + 4'd1;
      if (out_f) void'(sb_q.pop_front());
      if (in_f) begin
        e.pc = pc; e.data = data_of(pc);
        sb_q.push_back(e);
      end
    end
    m_ready = (sb_q.size() < 2);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_pc !== 32'h0 || o_data !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got v%b r%b pc %h data %h want v0 r0 pc 0 data 0",
                         o_valid, o_ready, o_pc, o_data);
    end
    checks++;
    if (o_stall_cnt !== 4'd0 || o_flush_cnt !== 4'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", o_ready);
    end
    // Fill both slots with stalls, then reset between clock edges.
    step(1'b1, 32'h100, 1'b1, 1'b0);
    step(1'b1, 32'h104, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 32'h0 || o_pc !== 32'h0 || o_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_outputs: got v%b r%b pc %h data %h want v0 r0 pc 0 data 0",
                         o_valid, o_ready, o_pc, o_data);
    end
    checks++;
    if (o_stall_cnt !== 4'd0 || o_flush_cnt !== 4'd0) begin
      errors++; $display("FAIL midreset_counters: got %0d/%0d want 0/0", o_stall_cnt, o_flush_cnt);
    end
    sb_q.delete(); m_ready = 1'b0; m_stall = 4'd0; m_flush = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_release_ready: got %b want 1", o_ready);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i * 4), 1'b1, 1'b0);
      checks++;
      if (o_valid !== 1'b1 || o_pc !== 32'(i * 4)) begin
        errors++; $display("FAIL stream_follow: got v%b pc %h want v1 pc %h", o_valid, o_pc, 32'(i * 4));
      end
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (o_stall_cnt !== 4'd0) begin
      errors++; $display("FAIL stream_stall_cnt: got %0d want 0", o_stall_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] np;
    logic            acc;
    np = 32'h200;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, np, 1'b1, 1'b0);
      np = np + 32'd4;
    end
    for (int k = 0; k < 3; k++) begin
      acc = m_ready;
      step(1'b1, np, 1'b0, 1'b0);
      if (acc) np = np + 32'd4;
    end
    checks++;
    if (o_ready !== 1'b0) begin
      errors++; $display("FAIL bp_ready_low: got %b want 0", o_ready);
    end
    checks++;
    if (o_stall_cnt !== 4'd3) begin
      errors++; $display("FAIL bp_stall_cnt: got %0d want 3", o_stall_cnt);
    end
    for (int k = 0; k < 4; k++) begin
      acc = m_ready;
      step(1'b1, np, 1'b1, 1'b0);
      if (acc) np = np + 32'd4;
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (sb_q.size() != 0 || o_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got v%b held %0d want v0 held 0", o_valid, sb_q.size());
    end
  endtask

  task automatic test_flush_two();
    step(1'b1, 32'h300, 1'b0, 1'b0);
    step(1'b1, 32'h304, 1'b0, 1'b0);
    step(1'b1, 32'h10, 1'b0, 1'b1);
    checks++;
    if (o_valid !== 1'b0 || o_data !== NOP || o_pc !== 32'h0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL flush_two_outputs: got v%b r%b pc %h data %h want v0 r1 pc 0 data %h",
                         o_valid, o_ready, o_pc, o_data, NOP);
    end
    checks++;
    if (o_flush_cnt !== 4'd1) begin
      errors++; $display("FAIL flush_two_cnt: got %0d want 1", o_flush_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (o_valid === 1'b1 && o_pc === 32'h10) begin
        errors++; $display("FAIL flush_two_leak: got pc %h want no entry", o_pc);
      end
    end
  endtask

  task automatic test_flush_empty();
    step(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (o_valid !== 1'b0 || o_pc !== 32'h0 || o_data !== NOP || o_ready !== 1'b1) begin
      errors++; $display("FAIL flush_empty_outputs: got v%b r%b pc %h data %h want v0 r1 pc 0 data %h",
                         o_valid, o_ready, o_pc, o_data, NOP);
    end
    checks++;
    if (o_flush_cnt !== 4'd1) begin
      errors++; $display("FAIL flush_empty_cnt: got %0d want 1", o_flush_cnt);
    end
  endtask

  task automatic test_saturation();
    step(1'b1, 32'h400, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (o_stall_cnt !== 4'hF) begin
      errors++; $display("FAIL sat_stall_cnt: got %0d want 15", o_stall_cnt);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    checks++;
    if (o_stall_cnt !== 4'hF || o_valid !== 1'b0) begin
      errors++; $display("FAIL sat_hold: got stall %0d v%b want 15 v0", o_stall_cnt, o_valid);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    m_ready = 1'b0; m_stall = 4'd0; m_flush = 4'd0;
    rst = 1'b1; i_valid = 1'b0; i_pc = 32'h0; i_data = 32'h0; i_flush = 1'b0; i_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_two();
    test_flush_empty();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
